// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, enable acts as stall, flush loads a bubble and beats stall.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (en_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS32 IF stage: PC register, next-PC mux and BOOT/RUN/HALT control.
// Optional MIPS_FETCH_STATS_EN adds fetch_count / stall_count outputs.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_d,
    input  logic [31:0] pc_target_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        halted
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    // 33-bit so a 2^30-word memory does not overflow the bound.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_DEPTH) * 33'(WORD_BYTES);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         out_of_range;
    logic         ifid_en;
    logic         ifid_flush;

    assign pc_plus4     = pc_q + WORD_BYTES;
    assign out_of_range = ({1'b0, pc_q} >= IMEM_BYTES);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            BOOT: begin
                ifid_flush = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (stall_f)       pc_d = pc_q;
                else if (pc_src_d) pc_d = align_word(pc_target_d);
                else               pc_d = pc_plus4;
                ifid_en    = !stall_f;
                // An out-of-range fetch never reaches decode, even if not flushed.
                ifid_flush = flush_d || (out_of_range && !stall_f);
                if (out_of_range && !stall_f && !pc_src_d) begin
                    state_d = HALT;
                    pc_d    = pc_q;
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ifid_en),
        .flush_i    (ifid_flush),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_plus4),
        .instr_o    (instr_d),
        .pc_plus4_o (pc_plus4_d),
        .valid_o    (valid_d)
    );

    assign imem_addr = pc_q;
    assign pc_f      = pc_q;
    assign halted    = (state_q == HALT);

`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (state_q == RUN) begin
            if (stall_f)
                stall_count_d = stall_count_q + 32'd1;
            if (!stall_f && !flush_d && !out_of_range)
                fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed steps plus randomized runs against a cycle model.
module tb_mips_fetch_stage;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall_f, flush_d, pc_src_d;
    logic [31:0] pc_target_d;
    logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_plus4_d;
    logic        valid_d, halted;
    logic [31:0] mem [0:DEPTH-1];

    assign imem_rdata = (imem_addr < LIMIT) ? mem[imem_addr[6:2]] : 32'hBAD0_BAD0;

    // Small-memory instance for the end-of-memory cases.
    logic        rst4_n, stall4, flush4, src4;
    logic [31:0] tgt4, addr4, rdata4, pc4_f, instr4, pcp4_4;
    logic        valid4, halted4;
    logic [31:0] mem4 [0:3];

    assign rdata4 = (addr4 < 32'd16) ? mem4[addr4[3:2]] : 32'hDEAD_BEEF;

`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, fetch4_count, stall4_count;
`endif

    mips_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
        .pc_src_d(pc_src_d), .pc_target_d(pc_target_d), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .halted(halted)
`ifdef MIPS_FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    mips_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .stall_f(stall4), .flush_d(flush4),
        .pc_src_d(src4), .pc_target_d(tgt4), .imem_addr(addr4),
        .imem_rdata(rdata4), .pc_f(pc4_f), .instr_d(instr4),
        .pc_plus4_d(pcp4_4), .valid_d(valid4), .halted(halted4)
`ifdef MIPS_FETCH_STATS_EN
        , .fetch_count(fetch4_count), .stall_count(stall4_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: "booting" / "stopped" flags and the IF/ID contents.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_booting;
    logic [31:0] m_fetch, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_booting = 1'b1;
        m_fetch = 32'h0; m_stall = 32'h0;
    endtask

    task automatic bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        logic        oor;
        if (m_halted) begin
            bubble();
        end else if (m_booting) begin
            bubble();
            m_booting = 1'b0;
        end else begin
            oor  = (m_pc >= LIMIT);
            word = oor ? 32'h0 : mem[m_pc / 4];
            if (stall_f) m_stall++;
            if (flush_d)           bubble();
            else if (stall_f)      ;
            else if (oor)          bubble();
            else begin
                m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_fetch++;
            end
            if (oor && !stall_f && !pc_src_d) m_halted = 1'b1;
            else if (stall_f)                 ;
            else if (pc_src_d)                m_pc = (pc_target_d / 4) * 4;
            else                              m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc_f"}, pc_f, m_pc);
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".instr_d"}, instr_d, m_instr);
        check({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4);
        check({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, m_valid});
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
`ifdef MIPS_FETCH_STATS_EN
        check({tag, ".fetch_count"}, fetch_count, m_fetch);
        check({tag, ".stall_count"}, stall_count, m_stall);
`endif
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input logic s, input logic f, input logic b, input logic [31:0] t);
        stall_f = s; flush_d = f; pc_src_d = b; pc_target_d = t;
    endtask

    task automatic tick4();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        stall4 = 1'b0; flush4 = 1'b0; src4 = 1'b0; tgt4 = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        for (int i = 0; i < 4; i++) mem4[i] = 32'h1000_0000 + 32'(i);
        model_reset();
        #1;
        compare_all("reset");

        // Reset then free-run.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("boot");
        tick("first");
        check("first_instr", instr_d, 32'h2008_0001);
        check("first_valid", {31'b0, valid_d}, 32'd1);
        tick("second");
        check("second_instr", instr_d, 32'h2009_0002);
        check("second_pc4", pc_plus4_d, 32'd8);
        tick("run_c");
        tick("run_10");
        check("at_0x10", pc_f, 32'h10);

        // Stall for three cycles.
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            check("stall_pc", pc_f, 32'h10);
            check("stall_instr", instr_d, mem[3]);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick("unstall");
        check("unstall_pc", pc_f, 32'h14);

        // Branch redirect with flush.
        set_in(1'b0, 1'b1, 1'b1, 32'h40);
        tick("redirect");
        check("redir_pc", pc_f, 32'h40);
        check("redir_bubble", {31'b0, valid_d}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick("after_redir");
        check("redir_word", instr_d, mem[16]);

        // Stall together with flush, then misaligned target.
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick("stall_flush");
        check("sf_pc", pc_f, 32'h44);
        check("sf_valid", {31'b0, valid_d}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick("sf_resume");
        set_in(1'b0, 1'b1, 1'b1, 32'h43);
        tick("misaligned");
        check("misaligned_pc", pc_f, 32'h40);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick("misaligned_next");

        // Randomized segments, each ending with an asynchronous reset mid-cycle.
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 150; c++) begin
                logic b;
                b = ($urandom % 6) == 0;
                set_in(($urandom % 4) == 0, b ? 1'b1 : (($urandom % 8) == 0), b,
                       32'($urandom_range(0, 32'h8F)));
                tick("rand");
            end
            #2;
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all("async_rst");
            #2;
            rst_n = 1'b1;
            set_in(1'b0, 1'b0, 1'b0, 32'h0);
        end

        // End of memory on the 4-word instance.
        rst4_n = 1'b1;
        repeat (5) tick4();
        check("eom_pc10", pc4_f, 32'h10);
        check("eom_last", instr4, mem4[3]);
        check("eom_not_yet", {31'b0, halted4}, 32'd0);
        tick4();
        check("eom_halted", {31'b0, halted4}, 32'd1);
        check("eom_pc_frozen", pc4_f, 32'h10);
        check("eom_bubble", {31'b0, valid4}, 32'd0);
        src4 = 1'b1; tgt4 = 32'h4;
        repeat (2) tick4();
        check("halt_ignores_pc", pc4_f, 32'h10);
        check("halt_stays", {31'b0, halted4}, 32'd1);
        check("halt_instr", instr4, 32'h0);
        src4 = 1'b0;
        #2;
        rst4_n = 1'b0;
        #1;
        check("rst4_pc", pc4_f, 32'h0);
        check("rst4_halted", {31'b0, halted4}, 32'd0);
        #2;
        rst4_n = 1'b1;
        repeat (5) tick4();
        src4 = 1'b1; tgt4 = 32'h8;
        tick4();
        check("eom_redir_nohalt", {31'b0, halted4}, 32'd0);
        check("eom_redir_pc", pc4_f, 32'h8);
        check("eom_redir_bubble", {31'b0, valid4}, 32'd0);
        src4 = 1'b0;
        tick4();
        check("eom_redir_word", instr4, mem4[2]);
        check("eom_redir_valid", {31'b0, valid4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch (IF) stage of the 5-stage MIPS32 pipeline. It owns the program counter, drives the instruction-memory read address, and registers the fetched word into the IF/ID pipeline register consumed by decode. It applies stall, flush and branch/jump redirect from the hazard unit and decode stage. It parks the pipeline in a halted state when the PC runs past the end of instruction memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_DEPTH`, default 256: instruction memory size in 32-bit words. Valid byte addresses are 0 .. IMEM_DEPTH*4-1.
- `clk`  in  1  pipeline clock. Everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_f`  in  1  hazard unit: hold PC and IF/ID.
- `flush_d`  in  1  hazard unit: replace IF/ID contents with a bubble.
- `pc_src_d`  in  1  decode: taken branch/jump, redirect fetch.
- `pc_target_d`  in  32  redirect target byte address.
- `imem_addr`  out  32  instruction-memory read address. Equals `pc_f`; the read is combinational.
- `imem_rdata`  in  32  instruction word at `imem_addr`, valid in the same cycle.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  IF/ID instruction.
- `pc_plus4_d`  out  32  IF/ID PC+4.
- `valid_d`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `halted`  out  1  fetch has stopped (HALT state).

## Operation
- State machine `fetch_state_t` has three states: BOOT, RUN, HALT.
- **Reset values:** state=BOOT, `pc_f`=RESET_PC, `instr_d`=NOP (32'h0), `pc_plus4_d`=0, `valid_d`=0, `halted`=0.
- **BOOT:** lasts one cycle after reset release. IF/ID is loaded with a bubble, the PC is held, and the state moves to RUN. This absorbs memory loading at release.
- **RUN next-PC priority:**
  1. If `stall_f`, hold the PC (this wins over redirect; the hazard unit never asserts both).
  2. Else if `pc_src_d`, load `{pc_target_d[31:2],2'b00}`.
  3. Else load `pc_f+4`, with 32-bit wrap.
- **RUN IF/ID update priority:**
  1. `flush_d` loads a bubble: NOP, `valid_d`=0, `pc_plus4_d`=0. This wins over `stall_f`.
  2. Else `stall_f` holds IF/ID.
  3. Else IF/ID loads `imem_rdata`, `pc_f+4`, `valid_d`=1.
- **Out of range:** when `pc_f` ≥ IMEM_DEPTH*4, `imem_rdata` is ignored and a bubble is loaded instead.
  - If `pc_src_d` and `stall_f` are both low in that cycle, go to HALT.
  - If `pc_src_d` is high, redirect normally; the speculative out-of-range fetch is discarded.
- **HALT:** PC frozen, IF/ID is a bubble every cycle, `halted`=1. All inputs are ignored. Only reset exits HALT.
- **Reset mid-operation:** all state and outputs return to reset values immediately (asynchronous), then BOOT is re-entered.
- No arithmetic beyond the 32-bit +4 adder. Wrap at 32'hFFFF_FFFC→0 is allowed but unreachable when IMEM_DEPTH is small.

## Timing
- IF→D latency is one cycle. The instruction at PC X appears on `instr_d` the edge after `pc_f`=X, unless stalled or flushed.
- The first valid instruction (RESET_PC) is on `instr_d` two edges after reset release: one BOOT cycle plus one fetch.
- A redirect asserted in cycle N makes `pc_f`=target in cycle N+1. The wrong-path word fetched in cycle N is removed by `flush_d` from the hazard unit in the same cycle N.
- A stall held for k cycles keeps `pc_f`, `instr_d` and `valid_d` unchanged for k cycles.
- `halted` rises the edge after the out-of-range fetch.

## Configuration
- `MIPS_FETCH_STATS_EN` defined adds two outputs:
  - `fetch_count` [31:0]: increments on every cycle IF/ID loads a valid instruction.
  - `stall_count` [31:0]: increments on every RUN cycle with `stall_f`=1.
  - Both reset to 0, wrap modulo 2^32, and freeze in HALT.
- Undefined: these ports and counters do not exist. Fetch behaviour is identical in both builds.

## Structure
- `mips_pkg` holds `fetch_state_t` (BOOT, RUN, HALT), the `NOP_INSTR` constant (32'h0000_0000), and the `WORD_BYTES` constant (4).
- One sub-module, `if_id_reg`: the IF/ID register, with async reset, stall (enable) and flush (synchronous bubble load), flush over stall.
- The top of this block keeps the PC register, next-PC mux and FSM.

## Test plan
- **Reset then free-run:** IMEM holds 0x20080001 at address 0 and 0x20090002 at address 4; reset is released. Expect `instr_d`=0x20080001 with `valid_d`=1 two edges after release, then 0x20090002 with `pc_plus4_d`=8.
- **Stall:** hold `stall_f` for 3 cycles while `pc_f`=0x10. Expect `pc_f`=0x10 and `instr_d` unchanged for 3 cycles, then `pc_f`=0x14.
- **Branch redirect:** `pc_src_d`=1, `pc_target_d`=0x40, `flush_d`=1 in one cycle. Expect `pc_f`=0x40 the next cycle, then `instr_d`=NOP with `valid_d`=0. The following cycle holds the word at 0x40.
- **Simultaneous:** `stall_f`=1 and `flush_d`=1 together. Expect PC held and IF/ID becomes a bubble. Misaligned target 0x43 is fetched as 0x40.
- **End of memory:** IMEM_DEPTH=4, no branches. Expect `halted`=1 one edge after `pc_f`=0x10, with PC frozen and `valid_d`=0 thereafter. With `pc_src_d`=1 at `pc_f`=0x10, expect no halt.
- **Async reset in RUN:** assert `rst_n`=0 mid-cycle. Expect `pc_f`=RESET_PC and `valid_d`=0 immediately, with no wait for a clock edge. With `MIPS_FETCH_STATS_EN` defined, the counters read 0.
